bsg_nonsynth_profiler_counter_bank: RTL and testbench

A parametrised bank of per-channel event counters for simulation profiling. It generalises the single-bit, one-event-per-cycle profiler client into `els_p` channels, each counting multi-unit increments per cycle, with a selectable saturate or wrap mode and sticky overflow flags. An atomic snapshot, with optional clear, can be taken at any idle cycle, and the snapshot is streamed out one channel per beat over a valid/ready port. It sits beside instrumented logic and feeds a profiler master or trace writer.

---
 rtl/bsg_nonsynth_profiler_counter_bank.sv | 137 +++++++++++++
 tb/tb_bsg_nonsynth_profiler_counter_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nonsynth_profiler_counter_bank.sv
// bsg_nonsynth_profiler_counter_bank: els_p multi-unit event counters
// (saturating or wrapping, sticky overflow) with an atomic snapshot
// that is streamed one channel per beat over a valid/ready port.
// Ports: clk_i, reset_n_i (sync, active-low); v_i/inc_i per-channel
// count enable and increment; clear_i zeroes live state; dump_i takes
// a snapshot; busy_o high while streaming; v_o/ready_i handshake with
// id_o, count_o, overflow_o, last_o describing the current entry.
module bsg_nonsynth_profiler_counter_bank #(
  parameter int els_p       = 32,
  parameter int width_p     = 32,
  parameter int inc_width_p = 1,
  parameter bit saturate_p  = 1'b1,
  parameter int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [els_p-1:0]             v_i,
  input  logic [els_p*inc_width_p-1:0] inc_i,
  input  logic                         clear_i,
  input  logic                         dump_i,
  output logic                         busy_o,
  output logic                         v_o,
  input  logic                         ready_i,
  output logic [lg_els_lp-1:0]         id_o,
  output logic [width_p-1:0]           count_o,
  output logic                         overflow_o,
  output logic                         last_o
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e               state_r, state_n;
  logic [lg_els_lp-1:0] ptr_r, ptr_n;
  logic [lg_els_lp-1:0] ptr_last;

  logic [width_p-1:0]   cnt_r [els_p];
  logic [width_p-1:0]   cnt_n [els_p];
  logic [els_p-1:0]     ovf_r, ovf_n;

  logic [width_p-1:0]   sh_cnt_r [els_p];
  logic [els_p-1:0]     sh_ovf_r;

  logic                 streaming;
  logic                 take_snap;
  logic                 at_last;

  assign ptr_last  = lg_els_lp'(els_p - 1);
  assign streaming = (state_r == STREAM);
  assign take_snap = reset_n_i & (state_r == IDLE) & dump_i;
  assign at_last   = (ptr_r == ptr_last);

  // Sum is formed one bit wider so the carry doubles as overflow.
  always_comb begin : live_next
    logic [width_p:0] sum;
    sum = '0;
    for (int k = 0; k < els_p; k++) begin
      cnt_n[k] = cnt_r[k];
      ovf_n[k] = ovf_r[k];
      sum = {1'b0, cnt_r[k]}
          + (width_p+1)'(inc_i[k*inc_width_p +: inc_width_p]);
      if (clear_i) begin
        cnt_n[k] = '0;
        ovf_n[k] = 1'b0;
      end else if (v_i[k]) begin
        if (sum[width_p]) begin
          ovf_n[k] = 1'b1;
          cnt_n[k] = saturate_p ? '1 : sum[width_p-1:0];
        end else begin
          cnt_n[k] = sum[width_p-1:0];
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_n = state_r;
    ptr_n   = ptr_r;
    unique case (state_r)
      IDLE: begin
        if (dump_i) begin
          state_n = STREAM;
          ptr_n   = '0;
        end
      end
      STREAM: begin
        if (ready_i) begin
          if (at_last) begin
            state_n = IDLE;
            ptr_n   = '0;
          end else begin
            ptr_n = ptr_r + lg_els_lp'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      ovf_r   <= '0;
      for (int k = 0; k < els_p; k++)
        cnt_r[k] <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      ovf_r   <= ovf_n;
      for (int k = 0; k < els_p; k++)
        cnt_r[k] <= cnt_n[k];
    end
  end

  // Snapshot captures pre-update live values; not reset on purpose.
  always_ff @(posedge clk_i) begin
    if (take_snap) begin
      sh_cnt_r <= cnt_r;
      sh_ovf_r <= ovf_r;
    end
  end

  // Gating keeps idle outputs at zero even though the shadow is unreset.
  assign busy_o     = streaming;
  assign v_o        = streaming;
  assign id_o       = streaming ? ptr_r : '0;
  assign count_o    = streaming ? sh_cnt_r[ptr_r] : '0;
  assign overflow_o = streaming & sh_ovf_r[ptr_r];
  assign last_o     = streaming & at_last;

endmodule

// File: tb/tb_bsg_nonsynth_profiler_counter_bank.sv
// Testbench for bsg_nonsynth_profiler_counter_bank: a wrapping and a
// saturating instance share stimulus and are checked against a model.
module tb_bsg_nonsynth_profiler_counter_bank;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int IW = 2;
  localparam int LG = 3;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  v;
  logic [N*IW-1:0] inc;
  logic          clr, dmp, rdy;

  logic          busy_w, vo_w, ovf_w, last_w;
  logic [LG-1:0] id_w;
  logic [W-1:0]  cnt_w;
  logic          busy_s, vo_s, ovf_s, last_s;
  logic [LG-1:0] id_s;
  logic [W-1:0]  cnt_s;

  bsg_nonsynth_profiler_counter_bank #(
    .els_p(N), .width_p(W), .inc_width_p(IW), .saturate_p(1'b0)
  ) dut_w (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .inc_i(inc),
    .clear_i(clr), .dump_i(dmp), .busy_o(busy_w), .v_o(vo_w),
    .ready_i(rdy), .id_o(id_w), .count_o(cnt_w),
    .overflow_o(ovf_w), .last_o(last_w)
  );

  bsg_nonsynth_profiler_counter_bank #(
    .els_p(N), .width_p(W), .inc_width_p(IW), .saturate_p(1'b1)
  ) dut_s (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .inc_i(inc),
    .clear_i(clr), .dump_i(dmp), .busy_o(busy_s), .v_o(vo_s),
    .ready_i(rdy), .id_o(id_s), .count_o(cnt_s),
    .overflow_o(ovf_s), .last_o(last_s)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: live values, snapshot, stream position.
  int lw[N], ls[N], low[N], los[N];
  int sw[N], ss[N], sow[N], sos[N];
  int mbusy = 0;
  int mptr = 0;

  // Beats captured by run_dump.
  int gid[N], gcw[N], gow[N], gcs[N], gos[N], glast[N];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    int a;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        lw[k] = 0; ls[k] = 0; low[k] = 0; los[k] = 0;
      end
      mbusy = 0;
      mptr = 0;
      return;
    end
    if (mbusy == 0 && dmp) begin
      sw = lw; ss = ls; sow = low; sos = los;
      mbusy = 1;
      mptr = 0;
    end else if (mbusy == 1 && rdy) begin
      if (mptr == N - 1) mbusy = 0;
      else mptr++;
    end
    for (int k = 0; k < N; k++) begin
      a = int'(inc[k*IW +: IW]);
      if (clr) begin
        lw[k] = 0; ls[k] = 0; low[k] = 0; los[k] = 0;
      end else if (v[k]) begin
        if (lw[k] + a > MAXV) low[k] = 1;
        if (ls[k] + a > MAXV) los[k] = 1;
        lw[k] = (lw[k] + a) % (MAXV + 1);
        ls[k] = (ls[k] + a > MAXV) ? MAXV : ls[k] + a;
      end
    end
  endfunction

  task automatic check_all();
    chk("busy_w", busy_w, mbusy);
    chk("busy_s", busy_s, mbusy);
    chk("v_w", vo_w, mbusy);
    chk("v_s", vo_s, mbusy);
    if (mbusy == 1) begin
      chk("id_w", id_w, mptr);
      chk("id_s", id_s, mptr);
      chk("cnt_w", cnt_w, sw[mptr]);
      chk("cnt_s", cnt_s, ss[mptr]);
      chk("ovf_w", ovf_w, sow[mptr]);
      chk("ovf_s", ovf_s, sos[mptr]);
      chk("last_w", last_w, mptr == N - 1);
      chk("last_s", last_s, mptr == N - 1);
    end else begin
      chk("idle_known_w", $isunknown({id_w, cnt_w, ovf_w, last_w}), 0);
      chk("idle_known_s", $isunknown({id_s, cnt_s, ovf_s, last_s}), 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1,0,1...; 2: random ready.
  task automatic run_dump(input int mode, input int mid_dump,
                          input bit clr_on_dump, input bit keep_v,
                          output int beats, output int busy_cyc,
                          output int dcyc);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int guard, pi;
    logic [LG-1:0] h_id;
    logic [W-1:0] h_cw, h_cs;
    guard = 0; pi = 0; beats = 0; busy_cyc = 0;
    for (int k = 0; k < N; k++) begin
      gid[k] = -1; gcw[k] = -1; gow[k] = -1;
      gcs[k] = -1; gos[k] = -1; glast[k] = -1;
    end
    dmp = 1'b1;
    clr = clr_on_dump;
    step();
    dcyc = cyc;
    dmp = 1'b0;
    clr = 1'b0;
    if (!keep_v) v = '0;
    while (vo_w === 1'b1 && guard < 100) begin
      guard++;
      case (mode)
        0: rdy = 1'b1;
        1: begin rdy = pat[pi % 6]; pi++; end
        default: rdy = 1'($urandom % 2);
      endcase
      dmp = (busy_cyc == mid_dump);
      busy_cyc++;
      if (rdy && beats < N) begin
        gid[beats] = int'(id_w);
        gcw[beats] = int'(cnt_w);
        gow[beats] = int'(ovf_w);
        gcs[beats] = int'(cnt_s);
        gos[beats] = int'(ovf_s);
        glast[beats] = int'(last_w);
        beats++;
      end
      h_id = id_w; h_cw = cnt_w; h_cs = cnt_s;
      step();
      if (!rdy) begin
        chk("hold_id", id_w, h_id);
        chk("hold_cnt_w", cnt_w, h_cw);
        chk("hold_cnt_s", cnt_s, h_cs);
      end
    end
    dmp = 1'b0;
    rdy = 1'b0;
    chk("stream_done", vo_w, 0);
  endtask

  int beats, bcyc, c1, c2, expv;

  initial begin
    rst_n = 1'b0; v = '0; inc = '0; clr = 1'b0; dmp = 1'b0; rdy = 1'b0;
    step();
    step();
    chk("rst_v", vo_w, 0);
    chk("rst_busy", busy_w, 0);
    chk("rst_last", last_w, 0);
    chk("rst_id", id_w, 0);
    chk("rst_cnt", cnt_w, 0);
    chk("rst_ovf", ovf_w, 0);
    rst_n = 1'b1;

    // Channel 2 += 3 for 5 cycles, then a full-speed dump.
    v = 8'b0000_0100;
    inc = 16'h0030;
    repeat (5) step();
    v = '0;
    run_dump(0, -1, 1'b0, 1'b0, beats, bcyc, c1);
    chk("wrap_beats", beats, N);
    chk("wrap_busy_len", bcyc, N);
    for (int k = 0; k < N; k++) begin
      chk("wrap_id", gid[k], k);
      chk("wrap_cnt", gcw[k], (k == 2) ? 15 : 0);
      chk("wrap_ovf", gow[k], 0);
      chk("wrap_last", glast[k], (k == N - 1) ? 1 : 0);
    end

    // Channel 0 += 1 for 20 cycles: saturate vs wrap.
    clr = 1'b1; step(); clr = 1'b0;
    v = 8'b0000_0001;
    inc = 16'h0001;
    repeat (20) step();
    run_dump(0, -1, 1'b0, 1'b0, beats, bcyc, c1);
    chk("sat_cnt", gcs[0], 15);
    chk("sat_ovf", gos[0], 1);
    chk("wrap20_cnt", gcw[0], 4);
    chk("wrap20_ovf", gow[0], 1);

    // Atomic dump-and-clear with a same-cycle increment.
    clr = 1'b1; step(); clr = 1'b0;
    v = 8'b0000_0010;
    inc = 16'h0004;
    repeat (7) step();
    run_dump(0, -1, 1'b1, 1'b0, beats, bcyc, c1);
    chk("dc_cnt", gcw[1], 7);
    chk("dc_cnt_s", gcs[1], 7);
    run_dump(0, -1, 1'b0, 1'b0, beats, bcyc, c1);
    for (int k = 0; k < N; k++) begin
      chk("dc2_cnt", gcw[k], 0);
      chk("dc2_ovf", gow[k], 0);
    end

    // Backpressure with random live contents.
    v = 8'($urandom);
    inc = 16'($urandom);
    repeat (6) step();
    v = '0;
    run_dump(1, -1, 1'b0, 1'b0, beats, bcyc, c1);
    chk("bp_beats", beats, N);
    for (int k = 0; k < N; k++)
      chk("bp_order", gid[k], k);

    // Counting across a stream; a mid-stream dump is ignored.
    clr = 1'b1; step(); clr = 1'b0;
    v = 8'b0000_1000;
    inc = 16'h0040;
    repeat (2) step();
    run_dump(0, 3, 1'b0, 1'b1, beats, bcyc, c1);
    chk("cs_pre", gcw[3], 2);
    chk("cs_beats", beats, N);
    chk("cs_busy_len", bcyc, N);
    run_dump(0, -1, 1'b0, 1'b0, beats, bcyc, c2);
    expv = (2 + c2 - c1) % (MAXV + 1);
    chk("cs_post", gcw[3], expv);

    // Reset while beat 2 is presented.
    v = 8'hff;
    inc = 16'h5555;
    repeat (3) step();
    v = '0;
    dmp = 1'b1; step(); dmp = 1'b0;
    rdy = 1'b1;
    step();
    step();
    chk("rm_beat2", id_w, 2);
    rst_n = 1'b0; rdy = 1'b0;
    step();
    chk("rm_v", vo_w, 0);
    chk("rm_busy", busy_w, 0);
    rst_n = 1'b1;
    run_dump(0, -1, 1'b0, 1'b0, beats, bcyc, c1);
    for (int k = 0; k < N; k++) begin
      chk("rm_zero", gcw[k], 0);
      chk("rm_zero_s", gcs[k], 0);
    end

    // Randomized traffic against the model.
    repeat (1500) begin
      v = 8'($urandom);
      inc = 16'($urandom);
      clr = ($urandom % 20) == 0;
      dmp = ($urandom % 8) == 0;
      rdy = 1'($urandom % 2);
      rst_n = ($urandom % 300) != 0;
      step();
    end
    rst_n = 1'b1; clr = 1'b0; dmp = 1'b0; rdy = 1'b1; v = '0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
